// File: rtl/cont4bits_checker.sv
// Observer for a WIDTH-bit up-counter: rebuilds Q from enable/dut_reset_n and compares every edge.
// Optional CHECK_TC_EN also compares tc against (expected==MAX)&&enable.
module cont4bits_checker #(
  parameter int WIDTH      = 4,
  parameter int MISS_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dut_reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] q,
  input  logic             tc,
  output logic [WIDTH-1:0] expected,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [7:0]       wrap_cnt,
  output logic             locked
);

  typedef enum logic [1:0] {SYNC, TRACK, LOST} state_t;

  localparam logic [WIDTH-1:0] MAX = '1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] expected_nx;
  logic             err_nx;
  logic [7:0]       err_cnt_nx;
  logic [7:0]       wrap_cnt_nx;
  logic [3:0]       miss, miss_nx;
  logic [3:0]       miss_inc;
  logic [WIDTH-1:0] en_inc;
  logic             mismatch;

  assign en_inc   = {{(WIDTH-1){1'b0}}, enable};
  assign miss_inc = miss + 4'd1;

`ifdef CHECK_TC_EN
  logic tc_exp;
  assign tc_exp   = (expected == MAX) && enable;
  assign mismatch = (q != expected) || (tc != tc_exp);
`else
  logic unused_tc;
  assign unused_tc = tc;
  assign mismatch  = (q != expected);
`endif

  assign locked = (state == TRACK);

  always_comb begin
    state_nx    = state;
    expected_nx = expected;
    err_nx      = 1'b0;
    err_cnt_nx  = err_cnt;
    wrap_cnt_nx = wrap_cnt;
    miss_nx     = miss;

    // Counter held in reset: its value is known to be 0, so tracking can resume directly.
    if (!dut_reset_n) begin
      expected_nx = '0;
      miss_nx     = '0;
      state_nx    = TRACK;
    end else begin
      unique case (state)
        SYNC: begin
          expected_nx = q + en_inc;
          miss_nx     = '0;
          state_nx    = TRACK;
        end
        TRACK: begin
          if (mismatch) begin
            err_nx      = 1'b1;
            err_cnt_nx  = (err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
            expected_nx = q + en_inc;
            miss_nx     = miss_inc;
            if (miss_inc >= 4'(MISS_LIMIT)) state_nx = LOST;
          end else begin
            expected_nx = expected + en_inc;
            miss_nx     = '0;
            if ((expected == MAX) && enable) wrap_cnt_nx = wrap_cnt + 8'd1;
          end
        end
        LOST: begin
          miss_nx  = '0;
          state_nx = SYNC;
        end
        default: state_nx = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SYNC;
      expected <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
      wrap_cnt <= '0;
      miss     <= '0;
    end else begin
      state    <= state_nx;
      expected <= expected_nx;
      err      <= err_nx;
      err_cnt  <= err_cnt_nx;
      wrap_cnt <= wrap_cnt_nx;
      miss     <= miss_nx;
    end
  end

endmodule

// File: tb/tb_cont4bits_checker.sv
// Directed bench: a reference counter drives q/tc, with override hooks to inject faults.
module tb_cont4bits_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dut_reset_n = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] q;
  logic       tc;
  logic [3:0] expected;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;
  logic       locked;

  logic [3:0] cnt;
  logic       frc = 1'b0;
  logic [3:0] frc_val = 4'd0;
  logic       tcf = 1'b0;
  logic       tcf_val = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Counter advances from whatever Q it currently shows, so a forced Q behaves like a real jump.
  always @(posedge clk or negedge dut_reset_n)
    if (!dut_reset_n) cnt <= 4'd0;
    else              cnt <= q + {3'b000, enable};

  assign q  = frc ? frc_val : cnt;
  assign tc = tcf ? tcf_val : ((q == 4'hF) && enable);

  cont4bits_checker #(.WIDTH(4), .MISS_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .dut_reset_n(dut_reset_n), .enable(enable),
    .q(q), .tc(tc), .expected(expected), .err(err), .err_cnt(err_cnt),
    .wrap_cnt(wrap_cnt), .locked(locked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Checker reset together with counter reset: checker reset has priority.
    reset = 1'b1; dut_reset_n = 1'b0; enable = 1'b0;
    tick();
    chk("rst_expected", 32'(expected), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_wrap_cnt", 32'(wrap_cnt), 0);
    chk("rst_locked", 32'(locked), 0);

    // Continuous counting through one wrap.
    reset = 1'b0; dut_reset_n = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("cnt_locked", 32'(locked), 1);
      chk("cnt_err", 32'(err), 0);
      chk("cnt_track", 32'(expected), 32'(q));
    end
    chk("cnt_final_exp", 32'(expected), 4);
    chk("cnt_wrap", 32'(wrap_cnt), 1);

    // Random enable with a counter reset pulse in the middle.
    for (int i = 0; i < 30; i++) begin
      enable = 1'($urandom_range(0, 1));
      dut_reset_n = (i != 10);
      tick();
      chk("rnd_track", 32'(expected), 32'(q));
      chk("rnd_err", 32'(err), 0);
    end
    chk("rnd_err_cnt", 32'(err_cnt), 0);

    // Restart from a known point, count to 4.
    reset = 1'b1; dut_reset_n = 1'b0; enable = 1'b0;
    tick();
    reset = 1'b0; dut_reset_n = 1'b1;
    tick();
    chk("re_sync_exp", 32'(expected), 0);
    enable = 1'b1;
    repeat (4) tick();
    chk("pre_glitch_exp", 32'(expected), 4);

    // Single glitch: q shows 7 while 4 is expected.
    frc = 1'b1; frc_val = 4'd7;
    tick();
    chk("glitch_err", 32'(err), 1);
    chk("glitch_err_cnt", 32'(err_cnt), 1);
    chk("glitch_resync", 32'(expected), 8);
    chk("glitch_locked", 32'(locked), 1);
    frc = 1'b0;
    tick();
    chk("glitch_err_clr", 32'(err), 0);
    chk("glitch_exp_next", 32'(expected), 9);

    // q stuck at 5: three misses, LOST, SYNC, TRACK, misses again.
    frc = 1'b1; frc_val = 4'd5;
    tick();
    chk("stuck1_err", 32'(err), 1);
    chk("stuck1_locked", 32'(locked), 1);
    tick();
    chk("stuck2_err", 32'(err), 1);
    chk("stuck2_locked", 32'(locked), 1);
    tick();
    chk("stuck3_err", 32'(err), 1);
    chk("stuck3_locked", 32'(locked), 0);
    chk("stuck3_err_cnt", 32'(err_cnt), 4);
    tick();
    chk("lost_err", 32'(err), 0);
    chk("lost_locked", 32'(locked), 0);
    chk("lost_err_cnt", 32'(err_cnt), 4);
    tick();
    chk("sync_err", 32'(err), 0);
    chk("sync_locked_after", 32'(locked), 1);
    chk("sync_exp", 32'(expected), 6);
    tick();
    chk("stuck4_err", 32'(err), 1);
    chk("stuck4_err_cnt", 32'(err_cnt), 5);

    // TC check at q=15 with tc forced low.
    frc = 1'b0; dut_reset_n = 1'b0; enable = 1'b0;
    tick();
    chk("dr_err", 32'(err), 0);
    chk("dr_exp", 32'(expected), 0);
    dut_reset_n = 1'b1; enable = 1'b1;
    repeat (15) tick();
    chk("tc_pre_exp", 32'(expected), 15);
    chk("tc_pre_err_cnt", 32'(err_cnt), 5);
    tcf = 1'b1; tcf_val = 1'b0;
    tick();
    tcf = 1'b0;
`ifdef CHECK_TC_EN
    chk("tc_err", 32'(err), 1);
    chk("tc_err_cnt", 32'(err_cnt), 6);
    chk("tc_wrap", 32'(wrap_cnt), 0);
`else
    chk("tc_err", 32'(err), 0);
    chk("tc_err_cnt", 32'(err_cnt), 5);
    chk("tc_wrap", 32'(wrap_cnt), 1);
`endif
    chk("tc_exp", 32'(expected), 0);

    // Stuck q yields three errors every five edges: 500 edges saturate err_cnt.
    frc = 1'b1; frc_val = 4'd5;
    repeat (500) tick();
    chk("sat_err_cnt", 32'(err_cnt), 255);
    repeat (10) tick();
    chk("sat_hold", 32'(err_cnt), 255);

    // Checker reset mid-stream.
    reset = 1'b1;
    tick();
    chk("mid_rst_expected", 32'(expected), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    chk("mid_rst_wrap", 32'(wrap_cnt), 0);
    chk("mid_rst_locked", 32'(locked), 0);

    // Resync, then a mismatch coinciding with counter reset must not raise err.
    reset = 1'b0; frc = 1'b0; enable = 1'b0;
    tick();
    chk("post_sync_track", 32'(expected), 32'(q));
    chk("post_sync_locked", 32'(locked), 1);
    frc = 1'b1; frc_val = 4'd9; dut_reset_n = 1'b0;
    tick();
    chk("drst_mis_err", 32'(err), 0);
    chk("drst_mis_exp", 32'(expected), 0);
    chk("drst_mis_err_cnt", 32'(err_cnt), 0);
    frc = 1'b0; dut_reset_n = 1'b1;
    tick();
    chk("drst_after_err", 32'(err), 0);
    chk("drst_after_locked", 32'(locked), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
